seq_shift_add_multiplier: RTL and testbench

- Unsigned sequential shift-and-add multiplier. It sits directly upstream of the N-bit ripple-carry Adder.
- It instantiates one Adder (same N) and drives it every iteration: A = accumulator, B = gated multiplicand, C_in = 0. It consumes S and C_out.
- Produces a 2N-bit product N+1 cycles after a start is accepted. Used by the ALU for the MUL operation.

---
 rtl/seq_shift_add_multiplier.sv | 129 ++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier. One partial product per RUN cycle
// is folded into the accumulator through an instantiated N-bit ripple-carry Adder.

module Adder #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic [N-1:0] S,
    output logic         C_out
);

    logic carry;

    always_comb begin
        S     = '0;
        carry = C_in;
        for (int unsigned i = 0; i < N; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        C_out = carry;
    end

endmodule

module seq_shift_add_multiplier #(
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A_in,
    input  logic [N-1:0]   B_in,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] p_q, p_d;

    logic [N-1:0]   add_b;
    logic [N-1:0]   add_s;
    logic           add_cout;
    logic [2*N-1:0] shifted;

    assign add_b = q_q[0] ? m_q : '0;

    Adder #(.N(N)) u_adder (
        .A     (acc_q),
        .B     (add_b),
        .C_in  (1'b0),
        .S     (add_s),
        .C_out (add_cout)
    );

    // The adder carry lands in the top bit, so the full 2N-bit product is kept.
    assign shifted = {add_cout, add_s, q_q[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = A_in;
                    q_d     = B_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                {acc_d, q_d} = shifted;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    p_d     = shifted;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign P    = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: N=16 vector table and handshake
// sequences, plus an exhaustive N=4 sweep on a second instance.

module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, busy16, done16;
    logic [15:0] A16, B16;
    logic [31:0] P16;
    logic        start4, busy4, done4;
    logic [3:0]  A4, B4;
    logic [7:0]  P4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A_in(A16), .B_in(B16),
        .busy(busy16), .done(done16), .P(P16)
    );

    seq_shift_add_multiplier #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A_in(A4), .B_in(B4),
        .busy(busy4), .done(done4), .P(P4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sample after each edge until done or the budget expires; start is left alone.
    task automatic wait_done16(output int edges, output int busyc);
        edges = 1;
        busyc = 0;
        while (!done16 && edges < 60) begin
            if (busy16) busyc++;
            tick();
            edges++;
        end
        chk("done16_seen", {63'd0, done16}, 64'd1);
    endtask

    // Launches one N=16 operation; inj>0 pulses start with other operands at that sample.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input int inj,
                         input logic [31:0] exp, input string nm);
        int edges, busyc;
        bit seen;
        A16 = a; B16 = b; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        edges = 1; busyc = 0; seen = 0;
        while (!seen && edges < 60) begin
            if (busy16) busyc++;
            if (done16) seen = 1;
            else begin
                if (edges == inj) begin
                    start16 = 1'b1; A16 = 16'd99; B16 = 16'd77;
                end else begin
                    start16 = 1'b0;
                end
                tick();
                edges++;
            end
        end
        start16 = 1'b0;
        chk({nm, "_seen"}, {63'd0, seen}, 64'd1);
        chk({nm, "_latency"}, 64'(edges), 64'd17);
        chk({nm, "_busycycles"}, 64'(busyc), 64'd16);
        chk({nm, "_P"}, {32'd0, P16}, {32'd0, exp});
        tick();
        chk({nm, "_done_fall"}, {63'd0, done16}, 64'd0);
        chk({nm, "_P_hold"}, {32'd0, P16}, {32'd0, exp});
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        int edges, busyc;
        logic [7:0] exp;
        exp = 8'(int'(a) * int'(b));
        A4 = a; B4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        edges = 1; busyc = 0;
        while (!done4 && edges < 20) begin
            if (busy4) busyc++;
            tick();
            edges++;
        end
        chk("n4_latency", 64'(edges), 64'd5);
        chk("n4_busycycles", 64'(busyc), 64'd4);
        chk("n4_P", {56'd0, P4}, {56'd0, exp});
        tick();
        chk("n4_done_width", {63'd0, done4}, 64'd0);
    endtask

    initial begin
        int edges, busyc, dn;

        vt[0] = '{16'd3,      16'd5,      32'd15};
        vt[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
        vt[2] = '{16'd0,      16'hFFFF,   32'd0};
        vt[3] = '{16'h8000,   16'd2,      32'h00010000};
        vt[4] = '{16'd1234,   16'd5678,   32'd7006652};
        vt[5] = '{16'hFFFF,   16'd1,      32'h0000FFFF};
        vt[6] = '{16'd1,      16'h8001,   32'h00008001};

        rst = 1'b1; start16 = 1'b0; start4 = 1'b0;
        A16 = '0; B16 = '0; A4 = '0; B4 = '0;
        #2;
        chk("rst_busy", {63'd0, busy16}, 64'd0);
        chk("rst_done", {63'd0, done16}, 64'd0);
        chk("rst_P", {32'd0, P16}, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_busy", {63'd0, busy16}, 64'd0);
            chk("idle_done", {63'd0, done16}, 64'd0);
            chk("idle_P", {32'd0, P16}, 64'd0);
        end

        for (int i = 0; i < 7; i++) run16(vt[i].a, vt[i].b, 0, vt[i].p, "vec");

        // Ignored mid-RUN start with different operands.
        run16(16'd3, 16'd5, 6, 32'd15, "midrun_start");

        // Back-to-back with start held high; operands swapped in the DONE cycle.
        A16 = 16'd7; B16 = 16'd9; start16 = 1'b1;
        tick();
        wait_done16(edges, busyc);
        chk("b2b1_latency", 64'(edges), 64'd17);
        chk("b2b1_P", {32'd0, P16}, 64'd63);
        A16 = 16'd100; B16 = 16'd200;
        tick();
        chk("b2b_done_fall", {63'd0, done16}, 64'd0);
        chk("b2b_busy_again", {63'd0, busy16}, 64'd1);
        chk("b2b_P_hold", {32'd0, P16}, 64'd63);
        wait_done16(edges, busyc);
        start16 = 1'b0;
        chk("b2b2_latency", 64'(edges), 64'd17);
        chk("b2b2_P", {32'd0, P16}, 64'd20000);
        tick();
        chk("b2b_idle", {62'd0, busy16, done16}, 64'd0);

        // Reset during RUN cycle 8.
        A16 = 16'd1234; B16 = 16'd5678; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        repeat (7) tick();
        chk("pre_rst_busy", {63'd0, busy16}, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy16}, 64'd0);
        chk("midrst_done", {63'd0, done16}, 64'd0);
        chk("midrst_P", {32'd0, P16}, 64'd0);
        tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done16 || busy16) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        run16(16'd1234, 16'd5678, 0, 32'd7006652, "after_rst");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run4(4'(a), 4'(b));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
